// File: rtl/register_128_unpacker_if.sv
// register_128_unpacker_if: word-in / beat-out handshake bundle for the 128-bit unpacker
//   in_data/in_valid/in_ready      : 128-bit word handshake from the upstream register stage
//   out_data/out_valid/out_ready   : beat handshake to the narrow downstream datapath
//   out_last                       : marks the final beat of a word
//   busy                           : a word is currently held
//   slave  : unpacker side, master : upstream source plus downstream sink
interface register_128_unpacker_if #(
   parameter int OUT_W = 32,
   parameter int BEATS = 4
);
   logic [OUT_W*BEATS-1:0] in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [OUT_W-1:0]       out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;
   logic                   busy;
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last, busy
   );
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/register_128_unpacker.sv
// register_128_unpacker: holds a 128-bit word and emits it as four 32-bit beats, LSB beat first
//   clock : system clock, rising edge
//   clr_n : asynchronous active-low reset
//   bus   : slave side of register_128_unpacker_if (word input, beat output, busy)
module register_128_unpacker #(
   parameter int OUT_W = 32,
   parameter int BEATS = 4
) (
   input logic                    clock,
   input logic                    clr_n,
   register_128_unpacker_if.slave bus
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t                 state_q;
   logic [1:0]             cnt_q;
   logic [OUT_W*BEATS-1:0] hold_q;
   logic                   send, last, take, fire;
   assign send = state_q == SEND;
   assign last = send && cnt_q == 2'(BEATS - 1);
   // a new word may land on the same edge the final beat leaves
   assign bus.in_ready  = !send || (last && bus.out_ready);
   assign take          = bus.in_valid && bus.in_ready;
   assign fire          = send && bus.out_ready;
   assign bus.out_valid = send;
   assign bus.out_last  = last;
   assign bus.busy      = send;
   // cnt is 0 in IDLE, so this also yields hold[31:0] there
   assign bus.out_data  = hold_q[OUT_W*cnt_q +: OUT_W];
   always_ff @(posedge clock or negedge clr_n)
      if (!clr_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else if (take) begin
         state_q <= SEND;
         cnt_q   <= '0;
         hold_q  <= bus.in_data;
      end else if (fire) begin
         // wraps to 0 after the final beat
         cnt_q <= cnt_q + 2'd1;
         if (last) state_q <= IDLE;
      end
endmodule

// File: tb/tb_register_128_unpacker.sv
// tb_register_128_unpacker: directed self-checking bench for register_128_unpacker
//   drives words and out_ready through the interface, checks beats against hand-written constants
module tb_register_128_unpacker;
   logic clock = 1'b0;
   logic clr_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   localparam logic [127:0] W = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] A = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
   localparam logic [127:0] B = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
   localparam logic [127:0] X = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
   register_128_unpacker_if bus ();
   register_128_unpacker dut (.clock(clock), .clr_n(clr_n), .bus(bus));
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   // check one beat whose expected value is given directly
   task automatic beat(input string tag, input logic [31:0] exp, input logic lst, input logic rdy);
      #1;
      chk({tag, " valid"}, 128'(bus.out_valid), 128'(1'b1));
      chk({tag, " data"},  128'(bus.out_data), 128'(exp));
      chk({tag, " last"},  128'(bus.out_last), 128'(lst));
      chk({tag, " in_ready"}, 128'(bus.in_ready), 128'(rdy));
      chk({tag, " busy"},  128'(bus.busy), 128'(1'b1));
      step();
   endtask
   task automatic idle_chk(input string tag);
      #1;
      chk({tag, " valid"}, 128'(bus.out_valid), 128'(1'b0));
      chk({tag, " last"},  128'(bus.out_last), 128'(1'b0));
      chk({tag, " busy"},  128'(bus.busy), 128'(1'b0));
      chk({tag, " in_ready"}, 128'(bus.in_ready), 128'(1'b1));
   endtask
   task automatic accept(input logic [127:0] w);
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      #1;
      chk("accept in_ready", 128'(bus.in_ready), 128'(1'b1));
      step();
      bus.in_valid = 1'b0;
   endtask
   initial begin
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #3;
      idle_chk("reset");
      chk("reset data", 128'(bus.out_data), 128'(32'h0));
      #4 clr_n = 1'b1;
      step();
      // single word, out_ready high
      accept(W);
      beat("single b0", 32'h11111111, 1'b0, 1'b0);
      beat("single b1", 32'h22222222, 1'b0, 1'b0);
      beat("single b2", 32'h33333333, 1'b0, 1'b0);
      beat("single b3", 32'h44444444, 1'b1, 1'b1);
      idle_chk("single done");
      step();
      // backpressure during beat 1
      accept(W);
      beat("bp b0", 32'h11111111, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp stall valid", 128'(bus.out_valid), 128'(1'b1));
         chk("bp stall data",  128'(bus.out_data), 128'(32'h22222222));
         chk("bp stall last",  128'(bus.out_last), 128'(1'b0));
         step();
      end
      bus.out_ready = 1'b1;
      beat("bp b1", 32'h22222222, 1'b0, 1'b0);
      beat("bp b2", 32'h33333333, 1'b0, 1'b0);
      beat("bp b3", 32'h44444444, 1'b1, 1'b1);
      idle_chk("bp done");
      step();
      // back-to-back A then B, B accepted on A's final beat
      accept(A);
      bus.in_data  = B;
      bus.in_valid = 1'b1;
      beat("b2b A0", 32'hA0A0A0A0, 1'b0, 1'b0);
      beat("b2b A1", 32'hA1A1A1A1, 1'b0, 1'b0);
      beat("b2b A2", 32'hA2A2A2A2, 1'b0, 1'b0);
      beat("b2b A3", 32'hA3A3A3A3, 1'b1, 1'b1);
      bus.in_valid = 1'b0;
      beat("b2b B0", 32'hB0B0B0B0, 1'b0, 1'b0);
      beat("b2b B1", 32'hB1B1B1B1, 1'b0, 1'b0);
      beat("b2b B2", 32'hB2B2B2B2, 1'b0, 1'b0);
      beat("b2b B3", 32'hB3B3B3B3, 1'b1, 1'b1);
      idle_chk("b2b done");
      step();
      // new word offered mid-word is ignored
      accept(W);
      beat("ign b0", 32'h11111111, 1'b0, 1'b0);
      bus.in_data  = X;
      bus.in_valid = 1'b1;
      beat("ign b1", 32'h22222222, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      beat("ign b2", 32'h33333333, 1'b0, 1'b0);
      beat("ign b3", 32'h44444444, 1'b1, 1'b1);
      idle_chk("ign done");
      step();
      // asynchronous reset in the middle of a word
      accept(W);
      beat("rst b0", 32'h11111111, 1'b0, 1'b0);
      #2 clr_n = 1'b0;
      idle_chk("midrst");
      chk("midrst data", 128'(bus.out_data), 128'(32'h0));
      step();
      #2 clr_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         idle_chk("after rst");
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
